logic_sweep_engine: RTL and testbench

//  Self-checking stimulus engine for small N-input combinational gates.
//  - Replaces free-running toggle benches.
//  - Sweeps all 2^N_IN input vectors into an external gate and holds each one HOLD_CYCLES clocks.
//  - Compares the gate output against a built-in golden model selected by op_sel.
//  - Reports an error count, the first failing vector and pass/done.

---
 rtl/logic_sweep_pkg.sv | 57 +++++
 rtl/logic_sweep_engine_gate_ref.sv | 16 +
 rtl/logic_sweep_engine.sv | 124 ++++++++++++
 tb/tb_logic_sweep_engine.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_sweep_pkg.sv
// Shared types and the golden reduction model for the logic sweep engine.
package logic_sweep_pkg;

    localparam int unsigned OP_W     = 3;
    localparam int unsigned MAX_N_IN = 8;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_BUF  = 3'd6,
        OP_NOT  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Reduces the low n bits of vec; BUF/NOT look at bit 0 only.
    function automatic logic expected(input logic [MAX_N_IN-1:0] vec,
                                      input int unsigned         n,
                                      input op_e                 op);
        logic all1;
        logic any1;
        logic par;
        logic res;
        all1 = 1'b1;
        any1 = 1'b0;
        par  = 1'b0;
        res  = 1'b0;
        for (int unsigned i = 0; i < MAX_N_IN; i++) begin
            if (i < n) begin
                all1 = all1 & vec[i];
                any1 = any1 | vec[i];
                par  = par ^ vec[i];
            end
        end
        case (op)
            OP_AND:  res = all1;
            OP_OR:   res = any1;
            OP_NAND: res = ~all1;
            OP_NOR:  res = ~any1;
            OP_XOR:  res = par;
            OP_XNOR: res = ~par;
            OP_BUF:  res = vec[0];
            OP_NOT:  res = ~vec[0];
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/logic_sweep_engine_gate_ref.sv
// Combinational golden model of an N_IN-input gate; reusable as a standalone checker.
module gate_ref
    import logic_sweep_pkg::*;
#(
    parameter int unsigned N_IN = 2
) (
    input  logic [N_IN-1:0] vec_i,
    input  op_e             op_i,
    output logic            expected_c
);

    always_comb begin
        expected_c = expected(MAX_N_IN'(vec_i), N_IN, op_i);
    end

endmodule

// File: rtl/logic_sweep_engine.sv
// Sweeps every input vector into an external gate, holds it, and checks the
// gate output against the golden model, keeping error count and first failure.
module logic_sweep_engine
    import logic_sweep_pkg::*;
#(
    parameter int unsigned N_IN        = 2,
    parameter int unsigned HOLD_CYCLES = 5,
    parameter int unsigned ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [OP_W-1:0]  op_sel,
    input  logic             dut_out,
    output logic [N_IN-1:0]  vec_o,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [N_IN-1:0]  first_fail
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    state_e            state_q;
    op_e               op_q;
    logic [N_IN-1:0]   vec_q;
    logic [N_IN-1:0]   first_fail_q;
    logic [HOLD_W-1:0] hold_q;
    logic [ERR_W-1:0]  err_q;
    logic [ERR_W-1:0]  err_d;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic              exp_c;
    logic              mismatch_c;

    gate_ref #(
        .N_IN(N_IN)
    ) u_gate_ref (
        .vec_i      (vec_q),
        .op_i       (op_q),
        .expected_c (exp_c)
    );

    // Mismatch detect and saturating increment of the error count.
    always_comb begin
        mismatch_c = (dut_out != exp_c);
        err_d      = (err_q == ERR_MAX) ? err_q : err_q + ERR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_AND;
            vec_q        <= '0;
            first_fail_q <= '0;
            hold_q       <= '0;
            err_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_q         <= op_e'(op_sel);
                        vec_q        <= '0;
                        hold_q       <= '0;
                        err_q        <= '0;
                        first_fail_q <= '0;
                        pass_q       <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Abort outranks the sample, so a final-cycle abort never reports done.
                    if (abort) begin
                        vec_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (hold_q == HOLD_LAST) begin
                        if (mismatch_c) begin
                            err_q <= err_d;
                            if (err_q == '0) begin
                                first_fail_q <= vec_q;
                            end
                        end
                        if (&vec_q) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_DONE;
                        end else begin
                            vec_q  <= vec_q + N_IN'(1);
                            hold_q <= '0;
                        end
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    pass_q  <= (err_q == '0);
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign vec_o      = vec_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_cnt    = err_q;
    assign first_fail = first_fail_q;

endmodule

// File: tb/tb_logic_sweep_engine.sv
// Bench for logic_sweep_engine: two instances (N_IN=2 and N_IN=4/ERR_W=2) checked against a truth-table model.
module tb_logic_sweep_engine;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
    logic [2:0]  op_a = 3'd0, op_b = 3'd0;
    logic [15:0] tt_a = '0, tt_b = '0;
    logic        dut_out_a, dut_out_b;

    logic [1:0] vec_a, ff_a;
    logic       busy_a, done_a, pass_a;
    logic [7:0] err_a;
    logic [3:0] vec_b, ff_b;
    logic       busy_b, done_b, pass_b;
    logic [1:0] err_b;

    assign dut_out_a = tt_a[vec_a];
    assign dut_out_b = tt_b[vec_b];

    logic_sweep_engine #(.N_IN(2), .HOLD_CYCLES(5), .ERR_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .op_sel(op_a),
        .dut_out(dut_out_a), .vec_o(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_cnt(err_a), .first_fail(ff_a)
    );

    logic_sweep_engine #(.N_IN(4), .HOLD_CYCLES(3), .ERR_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .op_sel(op_b),
        .dut_out(dut_out_b), .vec_o(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_cnt(err_b), .first_fail(ff_b)
    );

    int total = 0;
    int bad   = 0;
    bit sel   = 1'b0;

    logic       cur_busy, cur_done, cur_pass;
    logic [3:0] cur_vec, cur_ff;
    logic [7:0] cur_err;

    always_comb begin
        cur_busy = sel ? busy_b : busy_a;
        cur_done = sel ? done_b : done_a;
        cur_pass = sel ? pass_b : pass_a;
        cur_vec  = sel ? vec_b : {2'b00, vec_a};
        cur_ff   = sel ? ff_b : {2'b00, ff_a};
        cur_err  = sel ? {6'd0, err_b} : err_a;
    end

    function automatic int n_in();    return sel ? 4 : 2;   endfunction
    function automatic int hold();    return sel ? 3 : 5;   endfunction
    function automatic int max_err(); return sel ? 3 : 255; endfunction

    // Gate behaviour from the op table, using a count of ones.
    function automatic bit ref_gate(input int v, input int n, input int op);
        int ones;
        ones = $countones(v & ((1 << n) - 1));
        case (op)
            0: return ones == n;
            1: return ones > 0;
            2: return ones != n;
            3: return ones == 0;
            4: return (ones % 2) == 1;
            5: return (ones % 2) == 0;
            6: return (v % 2) == 1;
            default: return (v % 2) == 0;
        endcase
    endfunction

    // mode: 0 correct, 1 wired as AND, 2 stuck-at-0, 3 always wrong, 4 random faults
    function automatic logic [15:0] build_tt(input int op, input int mode);
        logic [15:0] tt;
        logic [15:0] rnd;
        rnd = 16'($urandom);
        for (int v = 0; v < 16; v++) begin
            case (mode)
                0: tt[v] = ref_gate(v, n_in(), op);
                1: tt[v] = ref_gate(v, n_in(), 0);
                2: tt[v] = 1'b0;
                3: tt[v] = ~ref_gate(v, n_in(), op);
                default: tt[v] = ref_gate(v, n_in(), op) ^ rnd[v];
            endcase
        end
        return tt;
    endfunction

    task automatic predict(input int op, input logic [15:0] tt, input int upto,
                           output int e, output int ff);
        int cnt;
        cnt = 0;
        ff  = 0;
        for (int v = 0; v < upto; v++) begin
            if (tt[v] != ref_gate(v, n_in(), op)) begin
                if (cnt == 0) ff = v;
                cnt++;
            end
        end
        e = (cnt > max_err()) ? max_err() : cnt;
    endtask

    task automatic drive(input bit st, input bit ab, input logic [2:0] op);
        if (sel) begin start_b = st; abort_b = ab; op_b = op; end
        else     begin start_a = st; abort_a = ab; op_a = op; end
    endtask

    // abort_at: edge (1..T) at which abort is sampled, or -1 for none.
    task automatic run_sweep(input int op, input int mode, input int abort_at,
                             input bit abort_with_start, input bit noisy);
        logic [15:0] tt;
        int          nv, h, t, e, ff;
        logic [18:0] obs, exp;
        logic [5:0]  obs_s, exp_s;
        tt = build_tt(op, mode);
        if (sel) tt_b = tt; else tt_a = tt;
        nv = 1 << n_in();
        h  = hold();
        t  = nv * h;
        @(negedge clk) drive(1'b1, abort_with_start, 3'(op));
        @(negedge clk) drive(1'b0, 1'b0, 3'(op));
        total++;
        obs = {cur_busy, cur_done, cur_vec, cur_err, cur_ff, cur_pass};
        exp = {1'b1, 1'b0, 4'd0, 8'd0, 4'd0, 1'b0};
        if (obs !== exp) begin
            bad++;
            $display("FAIL start_state sel=%0d op=%0d got=%h exp=%h", sel, op, obs, exp);
        end
        for (int k = 1; k <= t + 1; k++) begin
            drive(noisy ? 1'($urandom) : 1'b0, k == abort_at,
                  noisy ? 3'($urandom) : 3'(op));
            @(negedge clk);
            if (k == abort_at) begin
                drive(1'b0, 1'b0, 3'(op));
                predict(op, tt, (k - 1) / h, e, ff);
                total++;
                obs = {cur_busy, cur_done, cur_vec, cur_err, cur_ff, cur_pass};
                exp = {1'b0, 1'b0, 4'd0, 8'(e), 4'(ff), 1'b0};
                if (obs !== exp) begin
                    bad++;
                    $display("FAIL abort_state sel=%0d edge=%0d got=%h exp=%h", sel, k, obs, exp);
                end
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    total++;
                    if ({cur_busy, cur_done} !== 2'b00) begin
                        bad++;
                        $display("FAIL abort_quiet sel=%0d got busy=%b done=%b exp 0 0", sel, cur_busy, cur_done);
                    end
                end
                return;
            end
            total++;
            obs_s = {cur_busy, cur_done, cur_vec};
            exp_s = {1'(k < t), 1'(k == t + 1), (k < t) ? 4'(k / h) : 4'(nv - 1)};
            if (obs_s !== exp_s) begin
                bad++;
                $display("FAIL sweep_step sel=%0d cycle=%0d got=%b exp=%b", sel, k, obs_s, exp_s);
            end
        end
        drive(1'b0, 1'b0, 3'(op));
        predict(op, tt, nv, e, ff);
        total++;
        obs = {cur_busy, cur_done, cur_vec, cur_err, cur_ff, cur_pass};
        exp = {1'b0, 1'b1, 4'(nv - 1), 8'(e), 4'(ff), 1'(e == 0)};
        if (obs !== exp) begin
            bad++;
            $display("FAIL sweep_result sel=%0d op=%0d mode=%0d got=%h exp=%h", sel, op, mode, obs, exp);
        end
        @(negedge clk);
        total++;
        obs_s = {cur_busy, cur_done, cur_vec};
        exp_s = {1'b0, 1'b0, 4'(nv - 1)};
        if (obs_s !== exp_s) begin
            bad++;
            $display("FAIL after_done sel=%0d got=%b exp=%b", sel, obs_s, exp_s);
        end
    endtask

    task automatic test_reset();
        logic [31:0] obs;
        repeat (3) @(negedge clk);
        total++;
        obs = {busy_a, done_a, pass_a, err_a, ff_a, vec_a, busy_b, done_b, pass_b, err_b, ff_b, vec_b};
        if (obs !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", obs);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_clean_sweep();
        sel = 1'b0;
        run_sweep(2, 0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_wrong_gate();
        sel = 1'b0;
        run_sweep(2, 1, -1, 1'b0, 1'b0);
        total++;
        if ({err_a, ff_a, pass_a} !== {8'd4, 2'b00, 1'b0}) begin
            bad++;
            $display("FAIL nand_as_and got err=%0d ff=%0d pass=%b exp 4 0 0", err_a, ff_a, pass_a);
        end
        run_sweep(4, 2, -1, 1'b0, 1'b0);
        total++;
        if ({err_a, ff_a, pass_a} !== {8'd2, 2'b01, 1'b0}) begin
            bad++;
            $display("FAIL xor_stuck0 got err=%0d ff=%0d pass=%b exp 2 1 0", err_a, ff_a, pass_a);
        end
    endtask

    task automatic test_abort();
        sel = 1'b0;
        run_sweep(2, 4, 8, 1'b0, 1'b0);
        run_sweep(2, 0, -1, 1'b0, 1'b0);
        run_sweep(5, 3, 20, 1'b0, 1'b0);
        run_sweep(1, 4, 1, 1'b0, 1'b0);
    endtask

    task automatic test_start_abort_together();
        sel = 1'b0;
        run_sweep(0, 4, -1, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        logic [13:0] obs;
        sel = 1'b0;
        tt_a = build_tt(2, 3);
        @(negedge clk) drive(1'b1, 1'b0, 3'd2);
        @(negedge clk) drive(1'b0, 1'b0, 3'd2);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        obs = {busy_a, done_a, pass_a, err_a, ff_a, vec_a};
        if (obs !== '0) begin
            bad++;
            $display("FAIL async_reset got=%h exp=0", obs);
        end
        @(negedge clk) rst_n = 1'b1;
        run_sweep(2, 0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        sel = 1'b1;
        run_sweep(0, 3, -1, 1'b0, 1'b1);
        total++;
        if ({err_b, ff_b, pass_b} !== {2'd3, 4'd0, 1'b0}) begin
            bad++;
            $display("FAIL saturate got err=%0d ff=%0d pass=%b exp 3 0 0", err_b, ff_b, pass_b);
        end
        run_sweep(4, 0, -1, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        int op, ab, t;
        for (int i = 0; i < 10; i++) begin
            sel = 1'($urandom);
            op  = int'($urandom_range(7, 0));
            t   = sel ? 48 : 20;
            ab  = ($urandom_range(2, 0) == 0) ? int'($urandom_range(t, 1)) : -1;
            run_sweep(op, int'($urandom_range(4, 0)), ab, 1'($urandom), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_clean_sweep();
        test_wrong_gate();
        test_abort();
        test_start_abort_together();
        test_async_reset();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1, "timeout");
    end

endmodule
